// File: rtl/cheat_loader.sv
// Cheat-engine program loader: collects a checksummed frame from the MCU and
// replays it as program-port writes, deferring to SNES-side command writes.
module cheat_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mcu_start,
    input  logic [7:0]  mcu_data,
    input  logic        mcu_data_we,
    input  logic        pgm_block,
    output logic [2:0]  pgm_idx,
    output logic [31:0] pgm_in,
    output logic        pgm_we,
    output logic        busy,
    output logic [7:0]  status
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned NBUF   = 6;
    localparam int unsigned BCNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_PAYLOAD, ST_CSUM, ST_COMMIT
    } state_t;

    state_t state, state_nxt, state_eff;

    logic [WORD_W-1:0] word_buf [NBUF];
    logic [IDX_W-1:0]  base_idx, n_words, ptr, ptr_nxt;
    logic [BCNT_W-1:0] byte_cnt;
    logic [BYTE_W-1:0] csum_acc;
    logic              commit_valid;
    logic              done, err_csum, err_opcode, err_overrun, err_short;

    logic              restart, hdr_take, hdr_err, hdr_single, hdr_burst, hdr_clear;
    logic              pay_take, pay_last, csum_take, csum_ok, last_word;
    logic [IDX_W-1:0]  hdr_words, hdr_base;

    assign pgm_we = commit_valid & ~pgm_block;
    assign busy   = (state != ST_IDLE);
    assign status = {2'b00, err_short, err_overrun, err_opcode, err_csum, done, busy};

    // Next state; a start outside COMMIT makes the current byte a header.
    always_comb begin
        state_nxt  = state;
        hdr_take   = 1'b0;
        pay_take   = 1'b0;
        csum_take  = 1'b0;
        hdr_single = (mcu_data[7:4] == 4'h1) && !mcu_data[3];
        hdr_burst  = (mcu_data[7:4] == 4'h2) && !mcu_data[3] && (mcu_data[2:0] <= 3'd5);
        hdr_clear  = (mcu_data[7:4] == 4'h3) && !mcu_data[3];
        hdr_err    = !(hdr_single || hdr_burst || hdr_clear);
        hdr_words  = hdr_clear ? 3'd2 : (hdr_burst ? IDX_W'(3'd6 - mcu_data[2:0]) : 3'd1);
        hdr_base   = hdr_clear ? 3'd6 : mcu_data[2:0];
        restart    = mcu_start && (state != ST_COMMIT);
        state_eff  = restart ? ST_HDR : state;
        pay_last   = (byte_cnt == {IDX_W'(n_words - 3'd1), 2'b11});
        csum_ok    = (BYTE_W'(csum_acc + mcu_data) == '0);
        last_word  = (ptr == IDX_W'(n_words - 3'd1));
        ptr_nxt    = IDX_W'(ptr + 3'd1);
        state_nxt  = state_eff;
        case (state_eff)
            ST_IDLE: ;
            ST_HDR: begin
                if (mcu_data_we) begin
                    hdr_take = 1'b1;
                    if (hdr_err)        state_nxt = ST_IDLE;
                    else if (hdr_clear) state_nxt = ST_CSUM;
                    else                state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (mcu_data_we) begin
                    pay_take = 1'b1;
                    if (pay_last) state_nxt = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (mcu_data_we) begin
                    csum_take = 1'b1;
                    state_nxt = csum_ok ? ST_COMMIT : ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (pgm_we && last_word) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Frame bookkeeping, status flags and the program-port word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_idx     <= '0;
            n_words      <= '0;
            ptr          <= '0;
            byte_cnt     <= '0;
            csum_acc     <= '0;
            commit_valid <= 1'b0;
            pgm_idx      <= '0;
            pgm_in       <= '0;
            done         <= 1'b0;
            err_csum     <= 1'b0;
            err_opcode   <= 1'b0;
            err_overrun  <= 1'b0;
            err_short    <= 1'b0;
        end else begin
            if (restart) begin
                done        <= 1'b0;
                err_csum    <= 1'b0;
                err_opcode  <= 1'b0;
                err_overrun <= 1'b0;
                err_short   <= (state == ST_PAYLOAD) || (state == ST_CSUM);
            end
            if ((state == ST_COMMIT) && (mcu_start || mcu_data_we)) err_overrun <= 1'b1;
            if (hdr_take) begin
                csum_acc <= mcu_data;
                byte_cnt <= '0;
                n_words  <= hdr_words;
                base_idx <= hdr_base;
                if (hdr_err) err_opcode <= 1'b1;
            end
            if (pay_take) begin
                csum_acc <= BYTE_W'(csum_acc + mcu_data);
                byte_cnt <= BCNT_W'(byte_cnt + 5'd1);
            end
            if (csum_take) begin
                if (csum_ok) begin
                    commit_valid <= 1'b1;
                    ptr          <= '0;
                    pgm_idx      <= base_idx;
                    pgm_in       <= word_buf[0];
                end else begin
                    err_csum <= 1'b1;
                end
            end
            if (pgm_we) begin
                if (last_word) begin
                    commit_valid <= 1'b0;
                    done         <= 1'b1;
                end else begin
                    ptr     <= ptr_nxt;
                    pgm_idx <= IDX_W'(pgm_idx + 3'd1);
                    pgm_in  <= word_buf[ptr_nxt];
                end
            end
        end
    end

    // Payload bytes shift in big-endian; CLEAR preloads its two fixed words.
    always_ff @(posedge clk) begin
        if (hdr_take && hdr_clear) begin
            word_buf[0] <= '0;
            word_buf[1] <= 32'h0000_00F0;
        end
        if (pay_take) word_buf[byte_cnt[4:2]] <= {word_buf[byte_cnt[4:2]][23:0], mcu_data};
    end

endmodule

// File: tb/tb_cheat_loader.sv
// Self-checking bench for cheat_loader: frame-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized frames.
module tb_cheat_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mcu_start = 1'b0;
    logic [7:0]  mcu_data = 8'h00;
    logic        mcu_data_we = 1'b0;
    logic        pgm_block = 1'b0;
    logic [2:0]  pgm_idx;
    logic [31:0] pgm_in;
    logic        pgm_we;
    logic        busy;
    logic [7:0]  status;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { int cyc; logic [2:0] idx; logic [31:0] d; } wr_t;
    typedef struct { logic [2:0] idx; logic [31:0] d; } exp_t;

    wr_t        wlog[$];
    exp_t       wq[$];
    logic [7:0] fb[$];
    int         mode = 0;   // 0 idle, 1 collecting frame bytes, 2 committing wq
    bit m_done = 0, m_csum = 0, m_op = 0, m_ovr = 0, m_short = 0;

    cheat_loader dut (
        .clk(clk), .rst_n(rst_n), .mcu_start(mcu_start), .mcu_data(mcu_data),
        .mcu_data_we(mcu_data_we), .pgm_block(pgm_block), .pgm_idx(pgm_idx),
        .pgm_in(pgm_in), .pgm_we(pgm_we), .busy(busy), .status(status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Payload word count for a header, -1 when the header is illegal.
    function automatic int hdr_nw(input logic [7:0] h);
        if (h[3]) return -1;
        case (h[7:4])
            4'h1: return 1;
            4'h2: return (h[2:0] <= 3'd5) ? 6 - int'(h[2:0]) : -1;
            4'h3: return 0;
            default: return -1;
        endcase
    endfunction

    // Reference model: check outputs, then absorb the inputs the next edge samples.
    always @(negedge clk) begin : cmp
        logic       exp_we;
        int         nw;
        logic [7:0] sum;
        wr_t        w;
        exp_t       e;
        if (!rst_n) begin
            chk("rst_we", 64'(pgm_we), 64'd0);
            chk("rst_status", 64'(status), 64'd0);
            chk("rst_idx", 64'(pgm_idx), 64'd0);
            chk("rst_in", 64'(pgm_in), 64'd0);
            mode = 0;
            {m_done, m_csum, m_op, m_ovr, m_short} = '0;
            wq.delete();
            fb.delete();
        end else begin
            exp_we = (mode == 2) && !pgm_block;
            chk("pgm_we", 64'(pgm_we), 64'(exp_we));
            if (mode == 2) begin
                chk("pgm_idx", 64'(pgm_idx), 64'(wq[0].idx));
                chk("pgm_in", 64'(pgm_in), 64'(wq[0].d));
            end
            chk("status", 64'(status), 64'({2'b00, m_short, m_ovr, m_op, m_csum, m_done, mode != 0}));
            chk("busy", 64'(busy), 64'(mode != 0));
            if (pgm_we) begin
                w.cyc = cyc; w.idx = pgm_idx; w.d = pgm_in;
                wlog.push_back(w);
            end
            if (mode == 2) begin
                if (mcu_start || mcu_data_we) m_ovr = 1;
                if (exp_we) begin
                    void'(wq.pop_front());
                    if (wq.size() == 0) begin mode = 0; m_done = 1; end
                end
            end else begin
                if (mcu_start) begin
                    m_short = (mode == 1) && (fb.size() > 0);
                    {m_done, m_csum, m_op, m_ovr} = '0;
                    mode = 1;
                    fb.delete();
                end
                if (mcu_data_we && mode == 1) begin
                    fb.push_back(mcu_data);
                    nw = hdr_nw(fb[0]);
                    if (nw < 0) begin
                        m_op = 1; mode = 0;
                    end else if (fb.size() == 2 + 4 * nw) begin
                        sum = 8'd0;
                        foreach (fb[i]) sum = sum + fb[i];
                        if (sum == 8'd0) begin
                            if (nw == 0) begin
                                e.idx = 3'd6; e.d = 32'h0; wq.push_back(e);
                                e.idx = 3'd7; e.d = 32'hF0; wq.push_back(e);
                            end else begin
                                for (int k = 0; k < nw; k++) begin
                                    e.idx = 3'(int'(fb[0][2:0]) + k);
                                    e.d = {fb[1+4*k], fb[2+4*k], fb[3+4*k], fb[4+4*k]};
                                    wq.push_back(e);
                                end
                            end
                            mode = 2;
                        end else begin
                            m_csum = 1; mode = 0;
                        end
                    end
                end
            end
        end
    end

    // Present one cycle of inputs; c is the cycle in which they are presented.
    task automatic send(input logic s, input logic w, input logic [7:0] d, input logic b, output int c);
        mcu_start = s; mcu_data_we = w; mcu_data = d; pgm_block = b; c = cyc;
        @(posedge clk); #1;
        mcu_start = 1'b0; mcu_data_we = 1'b0; mcu_data = 8'h00; pgm_block = 1'b0;
    endtask

    task automatic frame(input logic [7:0] q[$], output int c);
        send(1'b1, 1'b0, 8'h00, 1'b0, c);
        foreach (q[i]) send(1'b0, 1'b1, q[i], 1'b0, c);
    endtask

    task automatic idle(input int n);
        int c;
        repeat (n) send(1'b0, 1'b0, 8'h00, 1'b0, c);
    endtask

    task automatic wait_idle(input int bound, input bit noisy);
        int c;
        int n = 0;
        while (busy && n < bound) begin
            send(1'b0, noisy && ($urandom % 8 == 0), 8'($urandom),
                 noisy && ($urandom % 3 == 0), c);
            n++;
        end
        chk("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        int c;
        int c2;
        logic [7:0] q[$];
        repeat (3) @(posedge clk);
        #1;
        chk("reset_status", 64'(status), 64'h00);
        rst_n = 1'b1;
        idle(2);

        // SINGLE to slot 2
        wlog.delete();
        frame('{8'h12, 8'h7E, 8'h12, 8'h34, 8'h56, 8'hD4}, c);
        idle(3);
        chk("single_count", 64'(wlog.size()), 64'd1);
        if (wlog.size() >= 1) begin
            chk("single_cyc", 64'(wlog[0].cyc), 64'(c + 1));
            chk("single_idx", 64'(wlog[0].idx), 64'd2);
            chk("single_data", 64'(wlog[0].d), 64'h7E123456);
        end
        chk("single_status", 64'(status), 64'h02);

        // BURST slots 4..5
        wlog.delete();
        frame('{8'h24, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h78}, c);
        idle(3);
        chk("burst_count", 64'(wlog.size()), 64'd2);
        if (wlog.size() >= 2) begin
            chk("burst_cyc0", 64'(wlog[0].cyc), 64'(c + 1));
            chk("burst_idx0", 64'(wlog[0].idx), 64'd4);
            chk("burst_data0", 64'(wlog[0].d), 64'h11223344);
            chk("burst_cyc1", 64'(wlog[1].cyc), 64'(c + 2));
            chk("burst_idx1", 64'(wlog[1].idx), 64'd5);
            chk("burst_data1", 64'(wlog[1].d), 64'h55667788);
        end

        // SINGLE with three blocked cycles right after the checksum
        wlog.delete();
        frame('{8'h12, 8'h7E, 8'h12, 8'h34, 8'h56, 8'hD4}, c);
        repeat (3) send(1'b0, 1'b0, 8'h00, 1'b1, c2);
        idle(3);
        chk("block_count", 64'(wlog.size()), 64'd1);
        if (wlog.size() >= 1) begin
            chk("block_cyc", 64'(wlog[0].cyc), 64'(c + 4));
            chk("block_data", 64'(wlog[0].d), 64'h7E123456);
        end

        // Bad checksum
        wlog.delete();
        frame('{8'h12, 8'h7E, 8'h12, 8'h34, 8'h56, 8'hD5}, c);
        idle(3);
        chk("badcsum_count", 64'(wlog.size()), 64'd0);
        chk("badcsum_status", 64'(status), 64'h04);
        chk("badcsum_busy", 64'(busy), 64'd0);

        // Illegal BURST index, trailing bytes ignored, then CLEAR
        wlog.delete();
        frame('{8'h26, 8'h11, 8'h22}, c);
        idle(2);
        chk("opcode_status", 64'(status), 64'h08);
        frame('{8'h30, 8'hD0}, c);
        idle(3);
        chk("clear_count", 64'(wlog.size()), 64'd2);
        if (wlog.size() >= 2) begin
            chk("clear_cyc0", 64'(wlog[0].cyc), 64'(c + 1));
            chk("clear_idx0", 64'(wlog[0].idx), 64'd6);
            chk("clear_data0", 64'(wlog[0].d), 64'h0);
            chk("clear_idx1", 64'(wlog[1].idx), 64'd7);
            chk("clear_data1", 64'(wlog[1].d), 64'hF0);
        end

        // Restart mid-payload, new frame still commits
        wlog.delete();
        frame('{8'h12, 8'h7E, 8'h12}, c);
        frame('{8'h12, 8'h7E, 8'h12, 8'h34, 8'h56, 8'hD4}, c);
        idle(3);
        chk("abort_status", 64'(status), 64'h22);
        chk("abort_count", 64'(wlog.size()), 64'd1);
        if (wlog.size() >= 1) chk("abort_data", 64'(wlog[0].d), 64'h7E123456);

        // Reset during a 6-word BURST commit
        wlog.delete();
        q = '{8'h20};
        for (int i = 0; i < 24; i++) q.push_back(8'(i * 7 + 3));
        c2 = 0;
        foreach (q[i]) c2 += int'(q[i]);
        q.push_back(8'(256 - (c2 % 256)));
        frame(q, c);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_we", 64'(pgm_we), 64'd0);
        chk("rstmid_status", 64'(status), 64'h00);
        chk("rstmid_count", 64'(wlog.size()), 64'd1);
        if (wlog.size() >= 1) chk("rstmid_idx0", 64'(wlog[0].idx), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Randomized frames against the model
        for (int f = 0; f < 250; f++) begin
            logic [7:0] h;
            logic [7:0] s;
            int nw, pl, trunc, first;
            q.delete();
            case ($urandom % 8)
                0, 1, 2: h = {4'h1, 1'b0, 3'($urandom)};
                3, 4:    h = {4'h2, 1'b0, 3'($urandom_range(0, 5))};
                5:       h = {4'h3, 1'b0, 3'($urandom)};
                default: h = 8'($urandom);
            endcase
            q.push_back(h);
            nw = hdr_nw(h);
            pl = (nw < 0) ? 2 : 4 * nw;
            repeat (pl) q.push_back(8'($urandom));
            s = 8'd0;
            foreach (q[i]) s = s + q[i];
            q.push_back(8'(8'd0 - s));
            if ($urandom % 5 == 0) q[q.size()-1] = q[q.size()-1] ^ 8'($urandom_range(1, 255));
            trunc = ($urandom % 10 == 0) ? int'($urandom_range(0, q.size() - 1)) : q.size();
            first = 0;
            if ($urandom % 4 == 0) begin
                send(1'b1, 1'b1, q[0], ($urandom % 3 == 0), c);
                first = 1;
            end else begin
                send(1'b1, 1'b0, 8'h00, ($urandom % 3 == 0), c);
            end
            for (int i = first; i < trunc; i++) begin
                repeat ($urandom % 3) send(1'b0, 1'b0, 8'h00, ($urandom % 3 == 0), c);
                send(1'b0, 1'b1, q[i], ($urandom % 3 == 0), c);
            end
            if (trunc == q.size()) wait_idle(400, 1'b1);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cheat_loader.md
# cheat_loader

MCU-side loader for the cheat/hook engine's program port. Receives a framed byte stream from the MCU command interface, buffers and checksums a complete frame, then replays it as single-cycle `pgm_we`/`pgm_idx`/`pgm_in` writes into the cheat engine. Writes are deferred while the engine's SNES-side command write has priority, so no program write is lost.

## Interface
- No parameters.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mcu_start`  in  1  strobe; begins a new frame.
- `mcu_data`  in  8  frame byte.
- `mcu_data_we`  in  1  strobe; `mcu_data` valid.
- `pgm_block`  in  1  high = engine busy with SNES command write; `pgm_we` must stay low.
- `pgm_idx`  out  3  program slot (0-5 cheat entries, 6 mask, 7 flags).
- `pgm_in`  out  32  program word.
- `pgm_we`  out  1  program write strobe.
- `busy`  out  1  frame in progress or committing.
- `status`  out  8  {2'b0, err_short, err_overrun, err_opcode, err_csum, done, busy}.

## Operation
- Frame: header H, payload (4 bytes per word, big-endian, first byte -> `pgm_in[31:24]`), checksum byte.
- H[7:4] opcode, H[3] must be 0, H[2:0] index:
  - 0x1 SINGLE: 1 word to slot H[2:0] (0-7).
  - 0x2 BURST: slots H[2:0]..5, 6-H[2:0] words; H[2:0] > 5 is illegal.
  - 0x3 CLEAR: no payload; commits slot 6 <- 0x00000000, then slot 7 <- 0x000000F0.
  - Any other opcode, H[3]=1, or illegal BURST index: set err_opcode, go IDLE.
- Checksum valid iff 8-bit sum of header, payload and checksum bytes == 0x00. Invalid: set err_csum, discard buffer, go IDLE, no `pgm_we`.
- Buffer: 6 x 32-bit words plus opcode/index/count registers.
- States: IDLE (bytes ignored), HDR (await header), PAYLOAD, CSUM, COMMIT.
  - IDLE/HDR/PAYLOAD/CSUM + `mcu_start` -> HDR. From PAYLOAD/CSUM this also sets err_short.
  - HDR + byte: decode -> PAYLOAD (SINGLE/BURST), CSUM (CLEAR), or IDLE (error).
  - PAYLOAD + byte: store. Last payload byte -> CSUM.
  - CSUM + byte: check -> COMMIT or IDLE.
  - COMMIT: after the last word is written -> IDLE, done=1.
- `mcu_start` clears done, err_csum, err_opcode, err_overrun and err_short before err_short is re-evaluated.
- `mcu_start` together with `mcu_data_we` in the same cycle: start takes effect and the byte is taken as the header of the new frame.
- In COMMIT, `mcu_start` and `mcu_data_we` are ignored and set err_overrun. The commit completes unaffected.
- `pgm_we = commit_valid & ~pgm_block` (combinational). `pgm_idx`/`pgm_in` are registered and held stable until the word is accepted. A word advances only in a cycle where `pgm_we` = 1.
- Slot index increments by 1 per word and never exceeds 7.
- `busy` = (state != IDLE).

## Timing
- Reset: all outputs 0, state IDLE, buffer contents don't-care. `rst_n` low mid-COMMIT drops any remaining words.
- Header byte accepted at cycle N -> new state visible at N+1.
- Checksum byte at cycle C, no block: first `pgm_we` at C+1. Subsequent words in consecutive cycles.
- Last `pgm_we` at cycle L -> state IDLE, `busy` = 0, done = 1 at L+1.
- Each `pgm_block` cycle during COMMIT delays the sequence by exactly one cycle.
- Bytes arriving with no gap (every cycle) are accepted.

## Test plan
- SINGLE: start, then 0x12, 0x7E, 0x12, 0x34, 0x56, 0xD4 -> one `pgm_we`, `pgm_idx`=2, `pgm_in`=0x7E123456, one cycle after the checksum byte; status = 0x02 the following cycle.
- BURST: start, header 0x24, payload 0x11223344 0x55667788, valid checksum -> `pgm_we` on two consecutive cycles: idx 4 = 0x11223344, then idx 5 = 0x55667788.
- Block: same SINGLE with `pgm_block` high for 3 cycles from C+1 -> `pgm_we` first at C+4; idx/data stable throughout; exactly one write.
- Bad checksum: SINGLE with final byte 0xD5 -> no `pgm_we`, status = 0x04, `busy` = 0.
- Opcode/CLEAR: header 0x26 -> err_opcode, further bytes ignored. Then start, 0x30, 0xD0 -> idx 6 = 0x00000000, then idx 7 = 0x000000F0.
- Abort/reset: start mid-PAYLOAD -> err_short = 1, and the new frame commits correctly. `rst_n` low during a BURST commit -> `pgm_we` = 0 immediately, status = 0x00.
